// File: rtl/mc_datapath_pkg.sv
// ============================================================================
//  Module  : mc_defs (package)
//  Purpose : Opcodes, function codes, sequencer states, ALU ops and immediate
//            extension helper shared by the multi-cycle MIPS-subset core.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_OR  = 3'd2,
        ALU_LUI = 3'd3,
        ALU_SLL = 3'd4
    } alu_op_e;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_mode_e mode);
        return (mode == EXT_SIGN) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_datapath_if.sv
// ============================================================================
//  Module  : mc_datapath_if
//  Purpose : Instruction/data memory handshakes plus the trace outputs of the
//            multi-cycle core. master = core side, slave = memory/trace side.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mc_datapath_if #(
    parameter int IM_AW = 12,
    parameter int DM_AW = 12
);
    logic             im_req;
    logic [IM_AW-1:0] im_addr;
    logic             im_ready;
    logic [31:0]      im_rdata;

    logic             dm_req;
    logic             dm_we;
    logic [DM_AW-1:0] dm_addr;
    logic [31:0]      dm_wdata;
    logic             dm_ready;
    logic [31:0]      dm_rdata;

    logic             wb_en;
    logic [4:0]       wb_reg;
    logic [31:0]      wb_data;
    logic [31:0]      pc_dbg;
    logic             retire;
    logic             illegal;

    modport master (
        output im_req, im_addr,
        input  im_ready, im_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ready, dm_rdata,
        output wb_en, wb_reg, wb_data, pc_dbg, retire, illegal
    );

    modport slave (
        input  im_req, im_addr,
        output im_ready, im_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ready, dm_rdata,
        input  wb_en, wb_reg, wb_data, pc_dbg, retire, illegal
    );
endinterface

`default_nettype wire

// File: rtl/mc_datapath_grf.sv
// ============================================================================
//  Module  : mc_grf
//  Purpose : 32x32 general register file, two combinational read ports and
//            one clocked write port; $0 is never written so it reads as zero.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_grf (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [4:0]  i_ra1,
    input  wire logic [4:0]  i_ra2,
    output logic      [31:0] o_rd1,
    output logic      [31:0] o_rd2,
    input  wire logic        i_we,
    input  wire logic [4:0]  i_wa,
    input  wire logic [31:0] i_wd
);
    logic [31:0] r_regs [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = r_regs[i_ra1];
    assign o_rd2 = r_regs[i_ra2];

endmodule

`default_nettype wire

// File: rtl/mc_datapath.sv
// ============================================================================
//  Module  : mc_datapath
//  Purpose : Multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB) with
//            req/ready handshakes to external instruction and data memories.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_datapath
    import mc_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_AW    = 12,
    parameter int          DM_AW    = 12
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mc_datapath_if.master bus
);
    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_cur;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] r_mdr;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [15:0] w_imm;
    logic        w_is_r;
    logic        w_addu;
    logic        w_subu;
    logic        w_sll;
    logic        w_jr;
    logic        w_ori;
    logic        w_lui;
    logic        w_lw;
    logic        w_sw;
    logic        w_beq;
    logic        w_jal;
    logic        w_legal;
    ext_mode_e   w_ext_mode;
    logic [31:0] w_ext;
    logic [31:0] w_alu_b;
    alu_op_e     w_alu_op;
    logic [31:0] w_alu_res;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic        w_wb_en;
    logic [4:0]  w_wb_reg;
    logic [31:0] w_wb_data;
    logic        w_retire;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_shamt = r_ir[10:6];
    assign w_funct = r_ir[5:0];
    assign w_imm   = r_ir[15:0];

    assign w_is_r  = (w_op == OP_RTYPE);
    assign w_addu  = w_is_r && (w_funct == FN_ADDU);
    assign w_subu  = w_is_r && (w_funct == FN_SUBU);
    assign w_sll   = w_is_r && (w_funct == FN_SLL);
    assign w_jr    = w_is_r && (w_funct == FN_JR);
    assign w_ori   = (w_op == OP_ORI);
    assign w_lui   = (w_op == OP_LUI);
    assign w_lw    = (w_op == OP_LW);
    assign w_sw    = (w_op == OP_SW);
    assign w_beq   = (w_op == OP_BEQ);
    assign w_jal   = (w_op == OP_JAL);
    assign w_legal = w_addu | w_subu | w_sll | w_jr | w_ori | w_lui |
                     w_lw | w_sw | w_beq | w_jal;

    assign w_ext_mode = w_ori ? EXT_ZERO : EXT_SIGN;
    assign w_ext      = extend_imm(w_imm, w_ext_mode);
    assign w_alu_b    = w_is_r ? r_b : w_ext;

    always_comb begin
        w_alu_op = ALU_ADD;
        if (w_subu)     w_alu_op = ALU_SUB;
        else if (w_ori) w_alu_op = ALU_OR;
        else if (w_lui) w_alu_op = ALU_LUI;
        else if (w_sll) w_alu_op = ALU_SLL;
    end

    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            ALU_ADD: w_alu_res = r_a + w_alu_b;
            ALU_SUB: w_alu_res = r_a - w_alu_b;
            ALU_OR:  w_alu_res = r_a | w_alu_b;
            ALU_LUI: w_alu_res = {w_imm, 16'h0000};
            ALU_SLL: w_alu_res = r_b << w_shamt;
            default: w_alu_res = '0;
        endcase
    end

    // jal links PC, which already holds the return address (PC+4)
    assign w_wb_en   = (r_state == S_WB);
    assign w_wb_reg  = w_is_r ? w_rd : (w_jal ? 5'd31 : w_rt);
    assign w_wb_data = w_lw ? r_mdr : (w_jal ? r_pc : r_aluout);

    mc_grf u_grf (
        .clk   (clk),
        .reset (reset),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rs_data),
        .o_rd2 (w_rt_data),
        .i_we  (w_wb_en),
        .i_wa  (w_wb_reg),
        .i_wd  (w_wb_data)
    );

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_DECODE: w_retire = !w_legal;
            S_EXEC:   w_retire = w_beq | w_jr;
            S_MEM:    w_retire = w_sw & bus.dm_ready;
            S_WB:     w_retire = 1'b1;
            default:  w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_pc_cur <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.im_ready) begin
                        r_ir     <= bus.im_rdata;
                        r_pc_cur <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a <= w_rs_data;
                    r_b <= w_rt_data;
                    if (w_jal)         r_state <= S_WB;
                    else if (!w_legal) r_state <= S_FETCH;
                    else               r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_aluout <= w_alu_res;
                    if (w_beq) begin
                        if (r_a == r_b) r_pc <= r_pc + {w_ext[29:0], 2'b00};
                        r_state <= S_FETCH;
                    end else if (w_jr) begin
                        r_pc    <= r_a;
                        r_state <= S_FETCH;
                    end else if (w_lw || w_sw) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dm_ready) begin
                        if (w_lw) begin
                            r_mdr   <= bus.dm_rdata;
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (w_jal) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // im_req is gated by reset so an in-flight fetch is abandoned immediately
    assign bus.im_req   = (r_state == S_FETCH) && !reset;
    assign bus.im_addr  = IM_AW'((r_pc - RESET_PC) >> 2);
    assign bus.dm_req   = (r_state == S_MEM);
    assign bus.dm_we    = (r_state == S_MEM) && w_sw;
    assign bus.dm_addr  = DM_AW'(r_aluout >> 2);
    assign bus.dm_wdata = r_b;
    assign bus.wb_en    = w_wb_en;
    assign bus.wb_reg   = w_wb_reg;
    assign bus.wb_data  = w_wb_data;
    assign bus.pc_dbg   = (r_state == S_FETCH) ? r_pc : r_pc_cur;
    assign bus.retire   = w_retire;
    assign bus.illegal  = (r_state == S_DECODE) && !w_legal;

endmodule

`default_nettype wire

// File: tb/tb_mc_datapath.sv
// ============================================================================
//  Module  : tb_mc_datapath
//  Purpose : Self-checking bench for mc_datapath: directed vector tables plus
//            random programs checked against an instruction-level ISA model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_datapath;

    localparam logic [31:0] FILLER = 32'h1000_ffff;   // beq $0,$0,-1

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_datapath_if #(.IM_AW(12), .DM_AW(12)) bus ();

    mc_datapath #(
        .RESET_PC (32'h0000_3000),
        .IM_AW    (12),
        .DM_AW    (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        int          cyc;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdat;
        logic        ill;
    } ret_t;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        int          len;
    } dmx_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdat;
        int          cyc;
        logic        ill;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] im_mem [4096];
    logic [31:0] dm_mem [4096];
    int im_wait = 0;
    int dm_wait = 0;
    int im_cnt  = 0;
    int dm_cnt  = 0;

    ret_t ret_q [$];
    dmx_t dm_q  [$];
    int   mon_cnt = 0;
    int   dm_len  = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_dm   [4096];
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Memory responders: ready after a programmable number of wait cycles
    always @(negedge clk) begin
        #1;
        if (bus.im_req) begin
            if (im_cnt >= im_wait) begin
                bus.im_ready = 1'b1;
                bus.im_rdata = im_mem[bus.im_addr];
                im_cnt = 0;
            end else begin
                bus.im_ready = 1'b0;
                bus.im_rdata = 32'hdead_beef;
                im_cnt++;
            end
        end else begin
            bus.im_ready = 1'b0;
            im_cnt = 0;
        end
        if (bus.dm_req) begin
            if (dm_cnt >= dm_wait) begin
                bus.dm_ready = 1'b1;
                if (bus.dm_we) dm_mem[bus.dm_addr] = bus.dm_wdata;
                else           bus.dm_rdata = dm_mem[bus.dm_addr];
                dm_cnt = 0;
            end else begin
                bus.dm_ready = 1'b0;
                dm_cnt++;
            end
        end else begin
            bus.dm_ready = 1'b0;
            dm_cnt = 0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset) begin
            mon_cnt = 0;
            dm_len  = 0;
        end else begin
            mon_cnt++;
            chk("req_exclusive", {31'b0, bus.im_req & bus.dm_req}, 32'h0);
            if (bus.dm_req) begin
                dm_len++;
                if (bus.dm_ready) begin
                    dm_q.push_back('{bus.dm_addr, bus.dm_we, dm_len});
                    dm_len = 0;
                end
            end
            if (bus.retire) begin
                ret_q.push_back('{bus.pc_dbg, mon_cnt, bus.wb_en, bus.wb_reg, bus.wb_data, bus.illegal});
                mon_cnt = 0;
            end
        end
    end

    task automatic assert_reset();
        @(negedge clk);
        #3;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        ret_q.delete();
        dm_q.delete();
    endtask

    task automatic fill_im();
        for (int i = 0; i < 4096; i++) im_mem[i] = FILLER;
    endtask

    task automatic wait_ret(output ret_t r, output bit ok);
        int n = 0;
        while (ret_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (ret_q.size() != 0);
        if (ok) r = ret_q.pop_front();
    endtask

    task automatic cmp_ret(input string tag, input ret_t g, input ret_t e);
        chk({tag, "_pc"},  g.pc, e.pc);
        chk({tag, "_cyc"}, 32'(g.cyc), 32'(e.cyc));
        chk({tag, "_wen"}, {31'b0, g.wen}, {31'b0, e.wen});
        chk({tag, "_ill"}, {31'b0, g.ill}, {31'b0, e.ill});
        if (e.wen) begin
            chk({tag, "_wreg"}, {27'b0, g.wreg}, {27'b0, e.wreg});
            chk({tag, "_wdat"}, g.wdat, e.wdat);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        ret_t g;
        ret_t e;
        bit   ok;
        wait_ret(g, ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no retire expected retire at pc %h", tag, v.pc);
        end else begin
            e = '{v.pc, v.cyc, v.wen, v.wreg, v.wdat, v.ill};
            cmp_ret(tag, g, e);
        end
    endtask

    // Instruction-level reference: architectural effect and zero-wait cost per instruction
    task automatic model_step(input logic [31:0] ins, output ret_t e);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sx;
        logic [31:0] addr;
        logic [31:0] npc;
        int          base;
        bit          mem;
        op   = ins[31:26];
        fn   = ins[5:0];
        a    = m_regs[ins[25:21]];
        b    = m_regs[ins[20:16]];
        sx   = {{16{ins[15]}}, ins[15:0]};
        addr = a + sx;
        npc  = m_pc + 32'd4;
        base = 4;
        mem  = 1'b0;
        e    = '{m_pc, 0, 1'b0, 5'd0, 32'd0, 1'b0};
        case (op)
            6'h00: begin
                case (fn)
                    6'h21: e = '{m_pc, 0, 1'b1, ins[15:11], a + b, 1'b0};
                    6'h23: e = '{m_pc, 0, 1'b1, ins[15:11], a - b, 1'b0};
                    6'h00: e = '{m_pc, 0, 1'b1, ins[15:11], b << ins[10:6], 1'b0};
                    6'h08: begin npc = a; base = 3; end
                    default: begin e.ill = 1'b1; base = 2; end
                endcase
            end
            6'h0d: e = '{m_pc, 0, 1'b1, ins[20:16], a | {16'h0, ins[15:0]}, 1'b0};
            6'h0f: e = '{m_pc, 0, 1'b1, ins[20:16], {ins[15:0], 16'h0}, 1'b0};
            6'h23: begin
                e = '{m_pc, 0, 1'b1, ins[20:16], m_dm[addr[13:2]], 1'b0};
                base = 5;
                mem = 1'b1;
            end
            6'h2b: begin
                m_dm[addr[13:2]] = b;
                mem = 1'b1;
            end
            6'h04: begin
                base = 3;
                if (a == b) npc = m_pc + 32'd4 + sx * 4;
            end
            6'h03: begin
                e = '{m_pc, 0, 1'b1, 5'd31, m_pc + 32'd4, 1'b0};
                npc = {npc[31:28], ins[25:0], 2'b00};
                base = 3;
            end
            default: begin e.ill = 1'b1; base = 2; end
        endcase
        e.cyc = base + im_wait + (mem ? dm_wait : 0);
        if (e.wen && e.wreg != 5'd0) m_regs[e.wreg] = e.wdat;
        m_pc = npc;
    endtask

    task automatic run_random(input int n, input int idx);
        ret_t g;
        ret_t e;
        bit   ok;
        int   guard;
        int   k;
        assert_reset();
        fill_im();
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0: im_mem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 6'h21);
                1: im_mem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 6'h23);
                2: im_mem[i] = enc_r(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31), 6'h00);
                3: im_mem[i] = enc_i(6'h0d, $urandom_range(0, 7), $urandom_range(1, 7), 16'($urandom));
                4: im_mem[i] = enc_i(6'h0f, 0, $urandom_range(0, 7), 16'($urandom));
                5: im_mem[i] = enc_i(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
                6: im_mem[i] = enc_i(6'h2b, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
                7: im_mem[i] = enc_i(6'h04, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom_range(0, 2)));
                8: im_mem[i] = enc_i(6'h3f, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
                default: im_mem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 6'h20);
            endcase
        end
        for (int i = 0; i < 4096; i++) begin
            dm_mem[i] = $urandom;
            m_dm[i]   = dm_mem[i];
        end
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc    = 32'h0000_3000;
        im_wait = $urandom_range(0, 2);
        dm_wait = $urandom_range(0, 2);
        release_reset();
        guard = 0;
        while (((m_pc - 32'h3000) >> 2) < 32'(n) && guard < 200) begin
            wait_ret(g, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL rnd%0d_timeout: got no retire expected retire at pc %h", idx, m_pc);
                break;
            end
            model_step(im_mem[(m_pc - 32'h3000) >> 2], e);
            cmp_ret($sformatf("rnd%0d_%0d", idx, guard), g, e);
            guard++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog");
    end

    vec_t tab [10];
    vec_t seq [7];
    dmx_t dx;
    int   n;

    initial begin
        bus.im_ready = 1'b0;
        bus.im_rdata = '0;
        bus.dm_ready = 1'b0;
        bus.dm_rdata = '0;

        tab[0] = '{enc_i(6'h0d, 0, 1, 16'h1234), 32'h3000, 1'b1, 5'd1, 32'h0000_1234, 4, 1'b0};
        tab[1] = '{enc_i(6'h0f, 0, 2, 16'hffff), 32'h3004, 1'b1, 5'd2, 32'hffff_0000, 4, 1'b0};
        tab[2] = '{enc_r(1, 2, 3, 0, 6'h21),     32'h3008, 1'b1, 5'd3, 32'hffff_1234, 4, 1'b0};
        tab[3] = '{enc_r(1, 2, 4, 0, 6'h23),     32'h300c, 1'b1, 5'd4, 32'h0001_1234, 4, 1'b0};
        tab[4] = '{enc_i(6'h2b, 0, 3, 16'h0008), 32'h3010, 1'b0, 5'd0, 32'h0,         7, 1'b0};
        tab[5] = '{enc_i(6'h23, 0, 5, 16'h0008), 32'h3014, 1'b1, 5'd5, 32'hffff_1234, 8, 1'b0};
        tab[6] = '{enc_r(1, 1, 0, 0, 6'h21),     32'h3018, 1'b1, 5'd0, 32'h0000_2468, 4, 1'b0};
        tab[7] = '{enc_r(0, 0, 6, 0, 6'h21),     32'h301c, 1'b1, 5'd6, 32'h0,         4, 1'b0};
        tab[8] = '{32'hfc00_0000,                32'h3020, 1'b0, 5'd0, 32'h0,         2, 1'b1};
        tab[9] = '{FILLER,                       32'h3024, 1'b0, 5'd0, 32'h0,         3, 1'b0};

        // Directed arithmetic / memory program, 3-wait data memory
        fill_im();
        for (int i = 0; i < 10; i++) im_mem[i] = tab[i].instr;
        for (int i = 0; i < 4096; i++) dm_mem[i] = '0;
        im_wait = 0;
        dm_wait = 3;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_im_req", {31'b0, bus.im_req}, 32'h0);
        chk("rst_dm_req", {31'b0, bus.dm_req}, 32'h0);
        chk("rst_retire", {31'b0, bus.retire}, 32'h0);
        chk("rst_wb_en",  {31'b0, bus.wb_en},  32'h0);
        chk("rst_pc_dbg", bus.pc_dbg, 32'h0000_3000);
        release_reset();
        #3;
        chk("boot_im_req",  {31'b0, bus.im_req}, 32'h1);
        chk("boot_im_addr", {20'b0, bus.im_addr}, 32'h0);
        for (int i = 0; i < 10; i++) check_vec($sformatf("arith%0d", i), tab[i]);
        chk("dm_txn_count", 32'(dm_q.size()), 32'd2);
        for (int i = 0; i < 2; i++) begin
            if (dm_q.size() != 0) begin
                dx = dm_q.pop_front();
                chk($sformatf("dm%0d_addr", i), {20'b0, dx.addr}, 32'h2);
                chk($sformatf("dm%0d_we", i),   {31'b0, dx.we}, (i == 0) ? 32'h1 : 32'h0);
                chk($sformatf("dm%0d_len", i),  32'(dx.len), 32'd4);
            end
        end
        chk("dm_word2", dm_mem[2], 32'hffff_1234);

        // Branch and jump program, zero-wait memories
        assert_reset();
        fill_im();
        im_mem[0] = enc_i(6'h0d, 0, 1, 16'h0005);
        im_mem[1] = 32'h0000_0000;
        im_mem[2] = {6'h03, 26'h000_0c08};
        im_mem[3] = enc_i(6'h04, 1, 1, 16'hffff);
        im_mem[8] = enc_r(31, 0, 0, 0, 6'h08);
        im_wait = 0;
        dm_wait = 0;
        seq[0] = '{32'h0, 32'h3000, 1'b1, 5'd1,  32'h5,      4, 1'b0};
        seq[1] = '{32'h0, 32'h3004, 1'b1, 5'd0,  32'h0,      4, 1'b0};
        seq[2] = '{32'h0, 32'h3008, 1'b1, 5'd31, 32'h300c,   3, 1'b0};
        seq[3] = '{32'h0, 32'h3020, 1'b0, 5'd0,  32'h0,      3, 1'b0};
        seq[4] = '{32'h0, 32'h300c, 1'b0, 5'd0,  32'h0,      3, 1'b0};
        seq[5] = '{32'h0, 32'h300c, 1'b0, 5'd0,  32'h0,      3, 1'b0};
        seq[6] = '{32'h0, 32'h300c, 1'b0, 5'd0,  32'h0,      3, 1'b0};
        release_reset();
        for (int i = 0; i < 7; i++) check_vec($sformatf("br%0d", i), seq[i]);

        // Reset while a store is waiting on dm_ready
        assert_reset();
        fill_im();
        im_mem[0] = enc_i(6'h2b, 0, 0, 16'h0004);
        dm_mem[1] = 32'h5a5a_5a5a;
        im_wait = 0;
        dm_wait = 10;
        release_reset();
        n = 0;
        #3;
        while (!bus.dm_req && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("midrst_dm_req_seen", {31'b0, bus.dm_req}, 32'h1);
        reset = 1'b1;
        #1;
        chk("midrst_dm_req_drop", {31'b0, bus.dm_req}, 32'h0);
        chk("midrst_im_req",      {31'b0, bus.im_req}, 32'h0);
        chk("midrst_pc_dbg",      bus.pc_dbg, 32'h0000_3000);
        release_reset();
        #3;
        chk("midrst_restart_req",  {31'b0, bus.im_req}, 32'h1);
        chk("midrst_restart_addr", {20'b0, bus.im_addr}, 32'h0);
        chk("midrst_no_store",     dm_mem[1], 32'h5a5a_5a5a);

        // Random programs against the ISA model
        for (int r = 0; r < 4; r++) run_random(30, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
